// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard and forwarding controller for the in-order pipeline.
// Tracks in-flight register writes from EX to WB and issues stalls and forwarding selects.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              flush_if_id,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [15:0]       stall_cycles
);

  localparam int unsigned    CW        = FW + 1;
  localparam logic [CW-1:0]  AVAIL_ALU = CW'(1);
  localparam logic [CW-1:0]  AVAIL_LD  = CW'(1 + LOAD_LAT);
  localparam logic [FW-1:0]  LAST      = FW'(DEPTH - 1);

  logic [DEPTH-1:0]  sb_valid;
  logic [DEPTH-1:0]  sb_load;
  logic [REG_AW-1:0] sb_rd [DEPTH];

  logic          hit_a, hit_b, ld_a, ld_b, haz_a, haz_b, accept;
  logic [FW-1:0] k_a, k_b, sel_a, sel_b;

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    k_a   = '0;
    k_b   = '0;
    // Scan oldest to youngest so the youngest matching producer wins.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (id_use_rs && id_rs != '0 && sb_valid[DEPTH-1-i] && sb_rd[DEPTH-1-i] == id_rs) begin
        hit_a = 1'b1;
        k_a   = FW'(DEPTH - 1 - i);
        ld_a  = sb_load[DEPTH-1-i];
      end
      if (id_use_rt && id_rt != '0 && sb_valid[DEPTH-1-i] && sb_rd[DEPTH-1-i] == id_rt) begin
        hit_b = 1'b1;
        k_b   = FW'(DEPTH - 1 - i);
        ld_b  = sb_load[DEPTH-1-i];
      end
    end
  end

  // Producer in entry k sits in stage k+1 when the consumer reaches EX.
  assign haz_a = hit_a && (({1'b0, k_a} + CW'(1)) < (ld_a ? AVAIL_LD : AVAIL_ALU));
  assign haz_b = hit_b && (({1'b0, k_b} + CW'(1)) < (ld_b ? AVAIL_LD : AVAIL_ALU));

  assign sel_a = (hit_a && k_a != LAST) ? k_a + FW'(1) : '0;
  assign sel_b = (hit_b && k_b != LAST) ? k_b + FW'(1) : '0;

  assign stall       = (haz_a | haz_b) & id_valid & ~flush;
  assign flush_if_id = flush;
  assign accept      = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_valid     <= '0;
      sb_load      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) sb_rd[i] <= '0;
      fwd_a        <= '0;
      fwd_b        <= '0;
      stall_cycles <= '0;
    end else begin
      sb_valid <= {sb_valid[DEPTH-2:0], accept & id_reg_write & (id_rd != '0)};
      sb_load  <= {sb_load[DEPTH-2:0], accept & id_is_load};
      for (int unsigned i = 1; i < DEPTH; i++) sb_rd[i] <= sb_rd[i-1];
      sb_rd[0] <= id_rd;
      fwd_a    <= accept ? sel_a : '0;
      fwd_b    <= accept ? sel_b : '0;
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: DEPTH=3/LOAD_LAT=1 and DEPTH=4/LOAD_LAT=2 instances,
// expected forwarding selects queued at issue and compared when the instruction is in EX.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid_s   [2];
  logic [4:0]  id_rs_s      [2];
  logic [4:0]  id_rt_s      [2];
  logic        id_use_rs_s  [2];
  logic        id_use_rt_s  [2];
  logic [4:0]  id_rd_s      [2];
  logic        id_reg_write_s [2];
  logic        id_is_load_s [2];
  logic        flush_s      [2];
  logic        stall_s      [2];
  logic        flush_if_id_s [2];
  logic [1:0]  fwd_a_s      [2];
  logic [1:0]  fwd_b_s      [2];
  logic [15:0] stall_cycles_s [2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         d;
    logic [1:0] fa;
    logic [1:0] fb;
    int         id;
  } exp_t;
  exp_t exp_q[$];
  int   step_no = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid_s[0]), .id_rs(id_rs_s[0]), .id_rt(id_rt_s[0]),
    .id_use_rs(id_use_rs_s[0]), .id_use_rt(id_use_rt_s[0]), .id_rd(id_rd_s[0]),
    .id_reg_write(id_reg_write_s[0]), .id_is_load(id_is_load_s[0]), .flush(flush_s[0]),
    .stall(stall_s[0]), .flush_if_id(flush_if_id_s[0]), .fwd_a(fwd_a_s[0]), .fwd_b(fwd_b_s[0]),
    .stall_cycles(stall_cycles_s[0])
  );

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid_s[1]), .id_rs(id_rs_s[1]), .id_rt(id_rt_s[1]),
    .id_use_rs(id_use_rs_s[1]), .id_use_rt(id_use_rt_s[1]), .id_rd(id_rd_s[1]),
    .id_reg_write(id_reg_write_s[1]), .id_is_load(id_is_load_s[1]), .flush(flush_s[1]),
    .stall(stall_s[1]), .flush_if_id(flush_if_id_s[1]), .fwd_a(fwd_a_s[1]), .fwd_b(fwd_b_s[1]),
    .stall_cycles(stall_cycles_s[1])
  );

  task automatic chk(input string tag, input int id, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, id, obs, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fwd_a", e.id, {14'd0, fwd_a_s[e.d]}, {14'd0, e.fa});
      chk("fwd_b", e.id, {14'd0, fwd_b_s[e.d]}, {14'd0, e.fb});
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic fl);
    id_valid_s[d]     = v;
    id_rs_s[d]        = rs;
    id_rt_s[d]        = rt;
    id_use_rs_s[d]    = urs;
    id_use_rt_s[d]    = urt;
    id_rd_s[d]        = rd;
    id_reg_write_s[d] = rw;
    id_is_load_s[d]   = ld;
    flush_s[d]        = fl;
  endtask

  // One ID cycle: check last EX selects, drive, check combinational outputs, queue EX expectation.
  task automatic step(input int d, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic fl,
                      input logic exp_st, input logic [1:0] efa, input logic [1:0] efb);
    exp_t e;
    @(negedge clk);
    drain();
    step_no++;
    drive(d, v, rs, rt, urs, urt, rd, rw, ld, fl);
    #1;
    chk("stall", step_no, {15'd0, stall_s[d]}, {15'd0, exp_st});
    chk("flush_if_id", step_no, {15'd0, flush_if_id_s[d]}, {15'd0, fl});
    e.d = d; e.fa = efa; e.fb = efb; e.id = step_no;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_stall", i, {15'd0, stall_s[i]}, 16'd0);
      chk("rst_flush", i, {15'd0, flush_if_id_s[i]}, 16'd0);
      chk("rst_fwd_a", i, {14'd0, fwd_a_s[i]}, 16'd0);
      chk("rst_fwd_b", i, {14'd0, fwd_b_s[i]}, 16'd0);
      chk("rst_cnt", i, stall_cycles_s[i], 16'd0);
    end
    reset = 1'b0;

    // DEPTH=3, LOAD_LAT=1
    step(0, 0, 5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd2,  5'd3,  1, 1, 5'd1,  1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd6,  5'd7,  1, 1, 5'd5,  1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd8,  5'd9,  1, 1, 5'd3,  1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd3,  5'd5,  1, 1, 5'd4,  1, 0, 0, 0, 2'd1, 2'd2);  // sub r4,r3,r5
    step(0, 1, 5'd11, 5'd12, 1, 1, 5'd10, 1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd14, 5'd15, 1, 1, 5'd13, 1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd10, 5'd0,  1, 1, 5'd20, 1, 0, 0, 0, 2'd2, 2'd0);
    step(0, 1, 5'd10, 5'd13, 1, 1, 5'd21, 1, 0, 0, 0, 2'd0, 2'd2);  // r10 now in last stage
    step(0, 1, 5'd17, 5'd0,  1, 0, 5'd2,  1, 1, 0, 0, 2'd0, 2'd0);  // lw r2
    step(0, 1, 5'd2,  5'd2,  1, 1, 5'd6,  1, 0, 0, 1, 2'd0, 2'd0);  // load-use stall
    step(0, 1, 5'd2,  5'd2,  1, 1, 5'd6,  1, 0, 0, 0, 2'd2, 2'd2);
    chk("cnt_loaduse", step_no, stall_cycles_s[0], 16'd1);
    step(0, 1, 5'd18, 5'd19, 1, 1, 5'd1,  1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd20, 5'd21, 1, 1, 5'd1,  1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd1,  5'd1,  1, 1, 5'd9,  1, 0, 0, 0, 2'd1, 2'd1);  // youngest r1 wins
    step(0, 1, 5'd22, 5'd23, 1, 1, 5'd0,  1, 0, 0, 0, 2'd0, 2'd0);  // write to r0
    step(0, 1, 5'd0,  5'd0,  1, 1, 5'd24, 1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd26, 5'd27, 1, 1, 5'd25, 0, 0, 0, 0, 2'd0, 2'd0);  // no reg_write
    step(0, 1, 5'd25, 5'd25, 1, 1, 5'd28, 1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd17, 5'd0,  1, 0, 5'd2,  1, 1, 0, 0, 2'd0, 2'd0);  // lw r2
    step(0, 1, 5'd2,  5'd2,  1, 1, 5'd26, 1, 0, 1, 0, 2'd0, 2'd0);  // flushed dependent
    chk("cnt_flush", step_no, stall_cycles_s[0], 16'd1);
    step(0, 1, 5'd26, 5'd2,  1, 1, 5'd27, 1, 0, 0, 0, 2'd0, 2'd2);
    step(0, 1, 5'd17, 5'd0,  1, 0, 5'd2,  1, 1, 0, 0, 2'd0, 2'd0);  // lw r2

    // Reset asserted while a load-use stall is active.
    @(negedge clk);
    drain();
    step_no++;
    drive(0, 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", step_no, {15'd0, stall_s[0]}, 16'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", step_no, {15'd0, stall_s[0]}, 16'd0);
    chk("mid_rst_cnt", step_no, stall_cycles_s[0], 16'd0);
    e.d = 0; e.fa = 2'd0; e.fb = 2'd0; e.id = step_no;
    exp_q.push_back(e);
    step(0, 0, 5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 0, 0, 2'd0, 2'd0);
    reset = 1'b0;

    // DEPTH=4, LOAD_LAT=2
    step(1, 1, 5'd27, 5'd0,  1, 0, 5'd7,  1, 1, 0, 0, 2'd0, 2'd0);  // lw r7
    step(1, 1, 5'd7,  5'd0,  1, 1, 5'd8,  1, 0, 0, 1, 2'd0, 2'd0);  // or r8,r7,r0
    step(1, 1, 5'd7,  5'd0,  1, 1, 5'd8,  1, 0, 0, 1, 2'd0, 2'd0);
    step(1, 1, 5'd7,  5'd0,  1, 1, 5'd8,  1, 0, 0, 0, 2'd3, 2'd0);
    chk("cnt_lat2", step_no, stall_cycles_s[1], 16'd2);
    step(1, 1, 5'd8,  5'd7,  1, 1, 5'd9,  1, 0, 0, 0, 2'd1, 2'd0);  // r7 in WB -> regfile
    step(1, 0, 5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 0, 0, 2'd0, 2'd0);

    @(negedge clk);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
